// File: rtl/bus_router_pkg.sv
// Shared types and the default SoC memory map for the bus router and its address decoder.
package bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam int NSLV_MAX = 8;
    localparam int IDX_W    = $clog2(NSLV_MAX);

    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_SIZE   = 32'h0001_0000;
    localparam logic [31:0] UART_BASE  = 32'h0100_0000;
    localparam logic [31:0] UART_SIZE  = 32'h0000_1000;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_SIZE = 32'h0001_0000;
    localparam logic [31:0] CLIC_BASE  = 32'h0300_0000;
    localparam logic [31:0] CLIC_SIZE  = 32'h0000_1000;
    localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
    localparam logic [31:0] BRAM_SIZE  = 32'h0010_0000;

    // Slot 0 is the least significant element; unused slots have size 0 and never hit.
    localparam logic [NSLV_MAX-1:0][31:0] DEF_SLV_BASE = {
        32'h0, 32'h0, 32'h0, BRAM_BASE, CLIC_BASE, CLINT_BASE, UART_BASE, ROM_BASE
    };
    localparam logic [NSLV_MAX-1:0][31:0] DEF_SLV_SIZE = {
        32'h0, 32'h0, 32'h0, BRAM_SIZE, CLIC_SIZE, CLINT_SIZE, UART_SIZE, ROM_SIZE
    };

    // End address is kept in 33 bits so a slot touching 4 GiB does not wrap to zero.
    function automatic logic [32:0] slot_end(input logic [31:0] base, input logic [31:0] size);
        return {1'b0, base} + {1'b0, size};
    endfunction

endpackage

// File: rtl/bus_router_decode.sv
// Combinational address decoder: lowest-index matching slot wins, offset is base-relative.
module bus_router_decode
    import bus_router_pkg::*;
#(
    parameter int                         NSLV     = 5,
    parameter logic [NSLV_MAX-1:0][31:0]  SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV_MAX-1:0][31:0]  SLV_SIZE = DEF_SLV_SIZE
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] index,
    output logic [31:0]      offset
);

    // Scanning from the top down lets the lowest matching slot overwrite the others.
    always_comb begin
        hit    = 1'b0;
        index  = '0;
        offset = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (({1'b0, addr} >= {1'b0, SLV_BASE[k]}) &&
                ({1'b0, addr} <  slot_end(SLV_BASE[k], SLV_SIZE[k]))) begin
                hit    = 1'b1;
                index  = IDX_W'(k);
                offset = addr - SLV_BASE[k];
            end
        end
    end

endmodule

// File: rtl/bus_router.sv
// Shares one arbitrated memory bus among NSLV slaves with a single outstanding transaction,
// producing decode-error and timeout-error responses and tracking slaves that answered late.
module bus_router
    import bus_router_pkg::*;
#(
    parameter int                         NSLV     = 5,
    parameter logic [NSLV_MAX-1:0][31:0]  SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV_MAX-1:0][31:0]  SLV_SIZE = DEF_SLV_SIZE,
    parameter int                         TIMEOUT  = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 memory_valid,
    input  logic                 memory_instr,
    input  logic [31:0]          memory_addr,
    input  logic [31:0]          memory_wdata,
    input  logic [3:0]           memory_wstrb,
    output logic [31:0]          memory_rdata,
    output logic                 memory_error,
    output logic                 memory_ready,
    output logic [NSLV-1:0]      slave_valid,
    output logic                 slave_instr,
    output logic [31:0]          slave_addr,
    output logic [31:0]          slave_wdata,
    output logic [3:0]           slave_wstrb,
    input  logic [NSLV*32-1:0]   slave_rdata,
    input  logic [NSLV-1:0]      slave_ready,
    output logic [NSLV-1:0]      slave_hung,
    output logic                 proto_err
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [NSLV-1:0]  hung_q, hung_d;
    logic             proto_q, proto_d;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic [31:0]      dec_off;

    logic [NSLV-1:0]  sel_oh, dec_oh;
    logic [31:0]      sel_rdata;
    logic             sel_ready, dec_hung;

    logic             count_clr, count_inc, timeout_hit;

    logic [NSLV-1:0]  valid_c;
    logic [31:0]      addr_c, rdata_c;
    logic             ready_c, err_c;

    bus_router_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_SIZE (SLV_SIZE)
    ) u_decode (
        .addr   (memory_addr),
        .hit    (dec_hit),
        .index  (dec_idx),
        .offset (dec_off)
    );

    always_comb begin
        sel_oh    = '0;
        dec_oh    = '0;
        sel_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            sel_oh[k] = (sel_q == IDX_W'(k));
            dec_oh[k] = (dec_idx == IDX_W'(k));
            if (sel_q == IDX_W'(k)) begin
                sel_rdata = slave_rdata[32*k +: 32];
            end
        end
    end

    assign sel_ready = |(slave_ready & sel_oh);
    assign dec_hung  = |(hung_q & dec_oh);

    // Any ready pulse retires a pending hung flag; a selected slot in BUSY is never hung.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        hung_d    = hung_q & ~slave_ready;
        proto_d   = proto_q;
        count_clr = 1'b0;
        count_inc = 1'b0;
        valid_c   = '0;
        addr_c    = '0;
        rdata_c   = '0;
        ready_c   = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_c = dec_off;
                if (memory_valid) begin
                    if (dec_hit && !dec_hung) begin
                        valid_c   = dec_oh;
                        sel_d     = dec_idx;
                        count_clr = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                rdata_c = sel_rdata;
                ready_c = sel_ready;
                if (memory_valid) proto_d = 1'b1;
                if (sel_ready) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    ready_c = 1'b1;
                    err_c   = 1'b1;
                    rdata_c = '0;
                    hung_d  = hung_d | sel_oh;
                    state_d = ST_IDLE;
                end else begin
                    count_inc = 1'b1;
                end
            end
            ST_ERR: begin
                ready_c = 1'b1;
                err_c   = 1'b1;
                if (memory_valid) proto_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            hung_q  <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hung_q  <= hung_d;
            proto_q <= proto_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] count_q, count_d;

            function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
                return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
            endfunction

            always_comb begin
                count_d = count_q;
                if (count_clr) begin
                    count_d = '0;
                end else if (count_inc) begin
                    count_d = sat_inc(count_q);
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign timeout_hit = (count_q == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            logic unused_cnt;
            assign unused_cnt  = count_clr | count_inc;
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Every output is forced low while reset is held, including the broadcast copies.
    assign memory_rdata = reset ? rdata_c : '0;
    assign memory_ready = reset & ready_c;
    assign memory_error = reset & err_c;
    assign slave_valid  = reset ? valid_c : '0;
    assign slave_addr   = reset ? addr_c : '0;
    assign slave_instr  = reset & memory_instr;
    assign slave_wdata  = reset ? memory_wdata : '0;
    assign slave_wstrb  = reset ? memory_wstrb : '0;
    assign slave_hung   = reset ? hung_q : '0;
    assign proto_err    = reset & proto_q;

endmodule
